// File: rtl/e_rr_alloc_pkg.sv
// Shared helpers for the round-robin slot allocator: derived widths and
// one-hot to binary encoding.
package e_pkg;

  localparam int MAX_N = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/e_priority.sv
// One priority segment: scans from the MSB down and grants the first clear
// x bit once armed; arming comes from cin_i or from passing a sel_i bit.
module e_priority #(
  parameter int W = 4
) (
  input  logic         cin_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] sel_i,
  output logic         vld_o,
  output logic [W-1:0] y_o,
  output logic         cout_o
);

  logic armed;
  logic found;

  always_comb begin
    armed = cin_i;
    found = 1'b0;
    y_o   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (armed && !x_i[i] && !found) begin
        y_o[i] = 1'b1;
        found  = 1'b1;
      end
      // Arm after the selected bit so the search starts strictly below it.
      armed = armed | sel_i[i];
    end
    vld_o  = found;
    cout_o = armed & ~found;
  end

endmodule

// File: rtl/e_priority_chain.sv
// SEGS e_priority segments chained from the top segment downward; the carry
// lets an arming seen in an upper segment continue the search below it.
module e_priority_chain #(
  parameter int W    = 4,
  parameter int SEGS = 2
) (
  input  logic                cin_i,
  input  logic [SEGS*W-1:0]   x_i,
  input  logic [SEGS*W-1:0]   sel_i,
  output logic                vld_o,
  output logic [SEGS*W-1:0]   y_o,
  output logic                cout_o
);

  logic [SEGS:0]   carry;
  logic [SEGS-1:0] seg_vld;

  assign carry[SEGS] = cin_i;

  for (genvar s = 0; s < SEGS; s++) begin : g_seg
    e_priority #(.W(W)) u_seg (
      .cin_i  (carry[s+1]),
      .x_i    (x_i[s*W +: W]),
      .sel_i  (sel_i[s*W +: W]),
      .vld_o  (seg_vld[s]),
      .y_o    (y_o[s*W +: W]),
      .cout_o (carry[s])
    );
  end

  // A segment only grants when no upper segment did, so y_o stays one-hot.
  assign vld_o  = |seg_vld;
  assign cout_o = carry[0];

endmodule

// File: rtl/e_rr_alloc.sv
// Round-robin slot allocator: offers the next free slot below the last grant,
// wrapping to the top, and tracks busy slots, their count and misuse.
module e_rr_alloc
  import e_pkg::*;
#(
  parameter int W     = 4,
  parameter int SEGS  = 2,
  parameter int IDX_W = idx_w(SEGS * W),
  parameter int CNT_W = cnt_w(SEGS * W)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              alloc_vld_o,
  input  logic              alloc_rdy_i,
  output logic [IDX_W-1:0]  alloc_idx_o,
  input  logic              free_vld_i,
  input  logic [IDX_W-1:0]  free_idx_i,
  output logic [SEGS*W-1:0] busy_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  localparam int N = SEGS * W;

  // Handshake: a slot is taken exactly on a cycle where alloc_vld_o and
  // alloc_rdy_i are both high; alloc_vld_o never waits on alloc_rdy_i.
  logic [N-1:0]     busy;
  logic [N-1:0]     ptr;
  logic [CNT_W-1:0] count;
  logic             err;

  logic [N-1:0]     a_y, b_y, cand, busy_n;
  logic             a_vld, b_vld, a_cout, b_cout;
  logic             acc, free_in_range, free_hit;
  logic [CNT_W-1:0] count_n;
  logic             unused_cout;

  e_priority_chain #(.W(W), .SEGS(SEGS)) u_pass_a (
    .cin_i  (1'b0),
    .x_i    (busy),
    .sel_i  (ptr),
    .vld_o  (a_vld),
    .y_o    (a_y),
    .cout_o (a_cout)
  );

  e_priority_chain #(.W(W), .SEGS(SEGS)) u_pass_b (
    .cin_i  (1'b1),
    .x_i    (busy),
    .sel_i  ('0),
    .vld_o  (b_vld),
    .y_o    (b_y),
    .cout_o (b_cout)
  );

  assign unused_cout = a_cout | b_cout;

  assign cand        = a_vld ? a_y : b_y;
  assign alloc_vld_o = a_vld | b_vld;
  assign alloc_idx_o = alloc_vld_o ? IDX_W'(onehot_to_idx(MAX_N'(cand))) : '0;

  assign acc           = alloc_vld_o & alloc_rdy_i;
  assign free_in_range = 32'(free_idx_i) < N;
  // Releasing a free or nonexistent slot is ignored apart from raising err.
  assign free_hit      = free_vld_i & free_in_range & (free_in_range ? busy[free_idx_i] : 1'b0);

  always_comb begin
    busy_n = busy;
    if (free_hit) busy_n[free_idx_i] = 1'b0;
    if (acc)      busy_n = busy_n | cand;
    count_n = count + CNT_W'(acc) - CNT_W'(free_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= '0;
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      busy  <= busy_n;
      count <= count_n;
      if (acc) ptr <= cand;
      if (free_vld_i && !free_hit) err <= 1'b1;
    end
  end

  assign busy_o  = busy;
  assign count_o = count;
  assign full_o  = (count == CNT_W'(N));
  assign empty_o = (count == '0);
  assign err_o   = err;

endmodule

// File: tb/tb_e_rr_alloc.sv
// Bench for e_rr_alloc: directed scenarios plus random traffic, all outputs
// compared every cycle against a slot-array reference model.
module tb_e_rr_alloc;

  localparam int W     = 4;
  localparam int SEGS  = 2;
  localparam int N     = SEGS * W;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             alloc_vld_o;
  logic             alloc_rdy_i;
  logic [IDX_W-1:0] alloc_idx_o;
  logic             free_vld_i;
  logic [IDX_W-1:0] free_idx_i;
  logic [N-1:0]     busy_o;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;
  logic             err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_busy[N];
  int m_ptr;
  int m_count;
  bit m_err;

  e_rr_alloc #(.W(W), .SEGS(SEGS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_vld_o (alloc_vld_o),
    .alloc_rdy_i (alloc_rdy_i),
    .alloc_idx_o (alloc_idx_o),
    .free_vld_i  (free_vld_i),
    .free_idx_i  (free_idx_i),
    .busy_o      (busy_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .err_o       (err_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: first free below the last grant, else highest free overall
  function automatic int model_offer();
    for (int i = m_ptr - 1; i >= 0; i--) if (!m_busy[i]) return i;
    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_busy_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    m_ptr   = 0;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit rdy, input bit fv, input int fidx);
    int  offer;
    bit  fok;
    if (!r) begin
      model_reset();
      return;
    end
    offer = model_offer();
    fok   = fv && (fidx < N) && m_busy[fidx];
    if (fv && !fok) m_err = 1'b1;
    if (fok) begin
      m_busy[fidx] = 1'b0;
      m_count--;
    end
    if (rdy && offer >= 0) begin
      m_busy[offer] = 1'b1;
      m_ptr = offer;
      m_count++;
    end
  endtask

  task automatic compare_all();
    int offer;
    offer = model_offer();
    check("alloc_vld", 32'(alloc_vld_o), 32'(offer >= 0));
    if (offer >= 0) check("alloc_idx", 32'(alloc_idx_o), 32'(offer));
    check("busy", 32'(busy_o), 32'(model_busy_vec()));
    check("count", 32'(count_o), 32'(m_count));
    check("full", 32'(full_o), 32'(m_count == N));
    check("empty", 32'(empty_o), 32'(m_count == 0));
    check("err", 32'(err_o), 32'(m_err));
  endtask

  // driver: called just after a falling edge; returns just after the next one
  task automatic cycle(input bit r, input bit rdy, input bit fv, input int fidx);
    compare_all();
    rst_n       = r;
    alloc_rdy_i = rdy;
    free_vld_i  = fv;
    free_idx_i  = IDX_W'(fidx);
    @(posedge clk);
    model_step(r, rdy, fv, fidx);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int exp_seq[7];
    rst_n       = 1'b0;
    alloc_rdy_i = 1'b0;
    free_vld_i  = 1'b0;
    free_idx_i  = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // fill from empty: grants 7 down to 0
    check("rst_vld", 32'(alloc_vld_o), 32'd1);
    check("rst_idx", 32'(alloc_idx_o), 32'd7);
    check("rst_empty", 32'(empty_o), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check("fill_idx", 32'(alloc_idx_o), 32'(7 - k));
      cycle(1'b1, 1'b1, 1'b0, 0);
    end
    check("fill_vld", 32'(alloc_vld_o), 32'd0);
    check("fill_full", 32'(full_o), 32'd1);
    check("fill_count", 32'(count_o), 32'd8);
    check("fill_busy", 32'(busy_o), 32'hFF);
    cycle(1'b1, 1'b1, 1'b0, 0);

    // free one slot from full, then take it back
    cycle(1'b1, 1'b0, 1'b1, 3);
    check("refree_vld", 32'(alloc_vld_o), 32'd1);
    check("refree_idx", 32'(alloc_idx_o), 32'd3);
    check("refree_count", 32'(count_o), 32'd7);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("refree_full", 32'(full_o), 32'd1);

    // wrap-around
    do_reset();
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b1, 7);
    cycle(1'b1, 1'b0, 1'b1, 6);
    check("wrap_busy", 32'(busy_o), 32'h20);
    exp_seq = '{4, 3, 2, 1, 0, 7, 6};
    for (int k = 0; k < 7; k++) begin
      check("wrap_idx", 32'(alloc_idx_o), 32'(exp_seq[k]));
      cycle(1'b1, 1'b1, 1'b0, 0);
    end
    check("wrap_full", 32'(full_o), 32'd1);

    // same-cycle accept and release
    do_reset();
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 0);
    for (int s = 7; s >= 4; s--) cycle(1'b1, 1'b0, 1'b1, s);
    check("sim_busy0", 32'(busy_o), 32'h0F);
    check("sim_idx0", 32'(alloc_idx_o), 32'd7);
    cycle(1'b1, 1'b1, 1'b1, 2);
    check("sim_busy1", 32'(busy_o), 32'h8B);
    check("sim_count", 32'(count_o), 32'd4);
    check("sim_idx1", 32'(alloc_idx_o), 32'd6);

    // double-free right after reset
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 4);
    check("dfree_err", 32'(err_o), 32'd1);
    check("dfree_busy", 32'(busy_o), 32'd0);
    check("dfree_empty", 32'(empty_o), 32'd1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 0);
    check("dfree_sticky", 32'(err_o), 32'd1);

    // reset in the middle of traffic
    do_reset();
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_count", 32'(count_o), 32'd0);
    check("mrst_err", 32'(err_o), 32'd0);
    check("mrst_idx", 32'(alloc_idx_o), 32'd7);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      bit r, rdy, fv;
      int fidx;
      r    = ($urandom_range(0, 99) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      fv   = ($urandom_range(0, 2) == 0);
      fidx = $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) != 0) begin
        for (int t = 0; t < N; t++) begin
          if (m_busy[(fidx + t) % N]) begin
            fidx = (fidx + t) % N;
            break;
          end
        end
      end
      cycle(r, rdy, fv, fidx);
    end
    compare_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
